mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm_pkg.sv | 94 +++++++++
 rtl/mc_ctrl_outdec.sv | 86 ++++++++
 rtl/mc_control_fsm.sv | 125 ++++++++++++
 tb/tb_mc_control_fsm.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - shared state, opcode and control-code definitions for mc_control_fsm
package mc_control_fsm_pkg;

  // State register encoding
  typedef logic [3:0] state_t;

  localparam state_t ST_INIT   = 4'd0;
  localparam state_t ST_FETCH  = 4'd1;
  localparam state_t ST_DECODE = 4'd2;
  localparam state_t ST_MEMADR = 4'd3;
  localparam state_t ST_MEMRD  = 4'd4;
  localparam state_t ST_MEMWB  = 4'd5;
  localparam state_t ST_MEMWR  = 4'd6;
  localparam state_t ST_EXEC   = 4'd7;
  localparam state_t ST_RWB    = 4'd8;
  localparam state_t ST_IEXEC  = 4'd9;
  localparam state_t ST_IWB    = 4'd10;
  localparam state_t ST_BRANCH = 4'd11;
  localparam state_t ST_JUMP   = 4'd12;

  // Supported opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU control decoder requests
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IROP  = 2'b11;

  // ALU B operand selects
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PC source selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Instruction class resolved in DECODE
  typedef enum logic [2:0] {
    CLS_LW,
    CLS_SW,
    CLS_R,
    CLS_I,
    CLS_BEQ,
    CLS_J,
    CLS_ILL
  } op_class_t;

  // Full set of datapath controls produced by the output decoder
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic op_class_t op_classify(input logic [5:0] op);
    op_class_t cls;
    case (op)
      OP_LW:    cls = CLS_LW;
      OP_SW:    cls = CLS_SW;
      OP_RTYPE: cls = CLS_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: cls = CLS_I;
      OP_BEQ:   cls = CLS_BEQ;
      OP_J:     cls = CLS_J;
      default:  cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - combinational state-to-control decoder for mc_control_fsm
module mc_ctrl_outdec
  import mc_control_fsm_pkg::*;
(
  input  state_t state,
  input  logic   mem_ok,
  input  logic   decode_illegal,
  output ctrl_t  ctrl
);

  // Each state drives only its listed controls; everything else stays 0.
  // mem_ok gates the strobes that must fire once per completed memory access.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ok;
        ctrl.pc_write  = mem_ok;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = decode_illegal;
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.memto_reg  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_write  = mem_ok;
        ctrl.ior_d      = 1'b1;
        ctrl.instr_done = mem_ok;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_IROP;
      end
      ST_IWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle CPU control FSM; MC_MEM_STALL_EN enables mem_ready stalls
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] IRop,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      PCSource,
  output logic [1:0]      ALUOp,
  output logic            instr_done,
  output logic            illegal
);

  state_t    state_q, state_d;
  op_class_t cls_q, cls_d;
  logic      start_q, start_d;
  op_class_t cls_in;
  logic      mem_ok;
  ctrl_t     ctrl;

`ifdef MC_MEM_STALL_EN
  assign mem_ok = mem_ready;
`else
  // Memory always completes in one cycle in this build.
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  // Opcode classification; any bits above the 6-bit opcode must be zero to be legal
  always_comb begin
    cls_in = CLS_ILL;
    if (IRop == OP_W'(IRop[5:0])) begin
      cls_in = op_classify(IRop[5:0]);
    end
  end

  // Next-state logic; the opcode class is captured only in DECODE
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    start_d = 1'b1;
    case (state_q)
      // start_q holds INIT for one full clock after reset release
      ST_INIT:   if (start_q) state_d = ST_FETCH;
      ST_FETCH:  if (mem_ok) state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d = cls_in;
        case (cls_in)
          CLS_LW, CLS_SW: state_d = ST_MEMADR;
          CLS_R:          state_d = ST_EXEC;
          CLS_I:          state_d = ST_IEXEC;
          CLS_BEQ:        state_d = ST_BRANCH;
          CLS_J:          state_d = ST_JUMP;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (cls_q == CLS_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  if (mem_ok) state_d = ST_MEMWB;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  if (mem_ok) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_RWB;
      ST_RWB:    state_d = ST_FETCH;
      ST_IEXEC:  state_d = ST_IWB;
      ST_IWB:    state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      default:   state_d = ST_INIT;
    endcase
  end

  // State, captured class and reset-release flag; async reset lands in INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cls_q   <= CLS_ILL;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      start_q <= start_d;
    end
  end

  mc_ctrl_outdec u_outdec (
    .state          (state_q),
    .mem_ok         (mem_ok),
    .decode_illegal (cls_in == CLS_ILL),
    .ctrl           (ctrl)
  );

  // Port fan-out of the decoded control bundle
  always_comb begin
    PCWrite     = ctrl.pc_write;
    PCWriteCond = ctrl.pc_write_cond;
    IorD        = ctrl.ior_d;
    MemRead     = ctrl.mem_read;
    MemWrite    = ctrl.mem_write;
    IRWrite     = ctrl.ir_write;
    MemtoReg    = ctrl.memto_reg;
    RegDst      = ctrl.reg_dst;
    RegWrite    = ctrl.reg_write;
    ALUSrcA     = ctrl.alu_src_a;
    ALUSrcB     = ctrl.alu_src_b;
    PCSource    = ctrl.pc_source;
    ALUOp       = ctrl.alu_op;
    instr_done  = ctrl.instr_done;
    illegal     = ctrl.illegal;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized instruction-stream bench for mc_control_fsm
module tb_mc_control_fsm;

`ifdef MC_MEM_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  localparam int N_INSTR = 150;
  localparam int MAX_CYC = 5000;

  // Micro-phases an instruction walks through, as listed for each instruction kind
  localparam int PH_INIT = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MEMADR = 3, PH_MEMRD = 4,
                 PH_MEMWB = 5, PH_MEMWR = 6, PH_EXEC = 7, PH_RWB = 8, PH_IEXEC = 9,
                 PH_IWB = 10, PH_BRANCH = 11, PH_JUMP = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] IRop;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal;
  logic [1:0] ALUSrcB, PCSource, ALUOp;

  always #5 clk = ~clk;

  mc_control_fsm #(.OP_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .IRop        (IRop),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .instr_done  (instr_done),
    .illegal     (illegal)
  );

  wire [17:0] obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done, illegal};

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [5:0] legal_ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001100,
                                 6'b001101, 6'b001110, 6'b001010, 6'b000100, 6'b000010};

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_itype(input logic [5:0] op);
    return op == 6'b001000 || op == 6'b001100 || op == 6'b001101 ||
           op == 6'b001110 || op == 6'b001010;
  endfunction

  // Cycles from FETCH entry through the instr_done cycle, inclusive, without stalls
  function automatic int base_lat(input logic [5:0] op);
    if (op == 6'b100011) return 5;
    if (op == 6'b000100 || op == 6'b000010) return 3;
    return 4;
  endfunction

  // Expected control word for a phase, from the per-phase strobe lists
  function automatic logic [17:0] expect_vec(input int ph, input bit rdy, input logic [5:0] op);
    bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, asa = 0;
    bit done = 0, ill = 0;
    logic [1:0] asb = 2'b00, pcs = 2'b00, aop = 2'b00;
    bit go = STALL ? rdy : 1'b1;
    case (ph)
      PH_FETCH:  begin mrd = 1; irw = go; pcw = go; asb = 2'b01; end
      PH_DECODE: begin asb = 2'b11; ill = !is_legal(op); end
      PH_MEMADR: begin asa = 1; asb = 2'b10; end
      PH_MEMRD:  begin mrd = 1; iord = 1; end
      PH_MEMWB:  begin rw = 1; m2r = 1; done = 1; end
      PH_MEMWR:  begin mwr = go; iord = 1; done = go; end
      PH_EXEC:   begin asa = 1; aop = 2'b10; end
      PH_RWB:    begin rw = 1; rdst = 1; done = 1; end
      PH_IEXEC:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
      PH_IWB:    begin rw = 1; done = 1; end
      PH_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      PH_JUMP:   begin pcw = 1; pcs = 2'b10; done = 1; end
      default:   ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, pcs, aop, done, ill};
  endfunction

  int ph_q[$];

  task automatic push_instr(input logic [5:0] op);
    ph_q.push_back(PH_FETCH);
    ph_q.push_back(PH_DECODE);
    if (op == 6'b100011) begin
      ph_q.push_back(PH_MEMADR); ph_q.push_back(PH_MEMRD); ph_q.push_back(PH_MEMWB);
    end else if (op == 6'b101011) begin
      ph_q.push_back(PH_MEMADR); ph_q.push_back(PH_MEMWR);
    end else if (op == 6'b000000) begin
      ph_q.push_back(PH_EXEC); ph_q.push_back(PH_RWB);
    end else if (is_itype(op)) begin
      ph_q.push_back(PH_IEXEC); ph_q.push_back(PH_IWB);
    end else if (op == 6'b000100) begin
      ph_q.push_back(PH_BRANCH);
    end else if (op == 6'b000010) begin
      ph_q.push_back(PH_JUMP);
    end
  endtask

  logic [5:0] directed [7] = '{6'b100011, 6'b000000, 6'b001000, 6'b000100,
                               6'b111111, 6'b101011, 6'b000010};

  initial begin
    logic [5:0] cur_op;
    int cyc, ph, fetch_cyc, stalls, n_instr, n_inject;
    bit hold;
    cur_op = '0; cyc = 0; fetch_cyc = -1; stalls = 0; n_instr = 0; n_inject = 0;
    rst_n = 1'b0; IRop = '0; mem_ready = 1'b0;

    #12;
    check("reset_outputs", obs, 18'h0);
    #1 rst_n = 1'b1;
    ph_q.push_back(PH_INIT);

    while (cyc < MAX_CYC && (n_instr < N_INSTR || ph_q.size() != 0)) begin
      @(posedge clk);
      #2;
      if (ph_q.size() == 0) begin
        if (n_instr < 7) cur_op = directed[n_instr];
        else if ($urandom_range(0, 3) != 0) cur_op = legal_ops[$urandom_range(0, 9)];
        else cur_op = 6'($urandom);
        push_instr(cur_op);
        n_instr++;
        fetch_cyc = -1;
        stalls = 0;
      end
      ph = ph_q[0];
      IRop = (ph == PH_DECODE) ? cur_op : 6'($urandom);
      mem_ready = ($urandom_range(0, 9) < 6);
      #2;
      check($sformatf("ctrl_ph%0d_op%02h", ph, cur_op), obs, expect_vec(ph, mem_ready, cur_op));
      if (ph == PH_FETCH && fetch_cyc < 0) fetch_cyc = cyc;
      hold = STALL && !mem_ready && (ph == PH_FETCH || ph == PH_MEMRD || ph == PH_MEMWR);
      if (hold) stalls++;
      if (instr_done)
        check($sformatf("latency_op%02h", cur_op), cyc - fetch_cyc + 1, base_lat(cur_op) + stalls);
      if (!hold) void'(ph_q.pop_front());
      cyc++;

      if (ph == PH_MEMWR && n_inject < 3 && $urandom_range(0, 2) == 0) begin
        n_inject++;
        #1 rst_n = 1'b0;
        #1 check("async_rst_memwr", obs, 18'h0);
        check("async_rst_memwrite", MemWrite, 1'b0);
        @(posedge clk);
        #1 check("rst_held", obs, 18'h0);
        #1 rst_n = 1'b1;
        ph_q.delete();
        ph_q.push_back(PH_INIT);
      end
    end

    if (cyc >= MAX_CYC) check("cycle_budget", 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
